// File: rtl/twi_pkg.sv
// Shared types and constants for the TWI frame decoder.
package twi_pkg;

  localparam int BYTE_W   = 8;
  localparam int BITCNT_W = 3;

  // Frame decoder states: waiting for START, shifting data bits, sampling the 9th (ACK) bit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    ACK  = 2'b10
  } state_t;

endpackage

// File: rtl/twi_edge_detect.sv
// Keeps the previous SCL/SDA levels and derives the bus events from them.
module twi_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_c,
  output logic stop_c
);

  logic scl_q;
  logic sda_q;

  // History registers start at the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_in;
      sda_q <= sda_in;
    end
  end

  // SDA moving while SCL is steadily high is a START (falling) or STOP (rising);
  // if SCL changes in the same cycle the SDA change is an ordinary data transition.
  assign scl_rise = scl_in & ~scl_q;
  assign scl_fall = ~scl_in & scl_q;
  assign start_c  = scl_q & scl_in & sda_q & ~sda_in;
  assign stop_c   = scl_q & scl_in & ~sda_q & sda_in;

endmodule

// File: rtl/twi_frame_decoder.sv
// Passive TWI frame decoder: frames bytes between START/STOP, reports ACK,
// address byte, framing errors and SCL stall timeouts. Never drives the bus.
module twi_frame_decoder
  import twi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              start_det,
  output logic              stop_det,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              ack_bit,
  output logic              is_addr,
  output logic              frame_err,
  output logic              timeout,
  output logic              busy
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(BYTE_W - 1);

  logic scl_rise;
  logic scl_fall;
  logic start_c;
  logic stop_c;

  state_t              state_q,     state_d;
  logic [BITCNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [BYTE_W-1:0]   shreg_q,     shreg_d;
  logic                first_q,     first_d;
  logic                rise_pend_q, rise_pend_d;
  logic [CNT_W-1:0]    tmo_q,       tmo_d;

  logic [BYTE_W-1:0]   byte_d;
  logic                ack_d;
  logic                addr_d;
  logic                start_d;
  logic                stop_d;
  logic                valid_d;
  logic                err_d;
  logic                tmo_pulse_d;
  logic                tmo_hit;
  logic                mid_byte;

  twi_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_c  (start_c),
    .stop_c   (stop_c)
  );

  // The SCL rise that opens a START/STOP clock has already been counted as a
  // bit; discount it while SCL is still high so a clean STOP/repeated START
  // after a complete byte is not reported as a framing error.
  assign mid_byte = (state_q == ACK) ||
                    ((state_q == DATA) && (bit_cnt_q > BITCNT_W'(rise_pend_q)));

  // Next-state, datapath and pulse decode; START/STOP beat timeout, timeout beats bit sampling.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    first_d     = first_q;
    rise_pend_d = rise_pend_q;
    tmo_d       = tmo_q;
    byte_d      = byte_out;
    ack_d       = ack_bit;
    addr_d      = is_addr;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    tmo_pulse_d = 1'b0;

    if (scl_rise) begin
      rise_pend_d = 1'b1;
    end else if (scl_fall) begin
      rise_pend_d = 1'b0;
    end

    if ((state_q == IDLE) || scl_rise || scl_fall || start_c || stop_c) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_LIMIT) begin
      tmo_d = tmo_q + CNT_W'(1);
    end
    tmo_hit = (state_q != IDLE) && (tmo_d == TMO_LIMIT);

    case (state_q)
      IDLE: begin
        if (start_c) begin
          start_d   = 1'b1;
          state_d   = DATA;
          bit_cnt_d = '0;
          first_d   = 1'b1;
        end
      end

      DATA, ACK: begin
        if (start_c) begin
          start_d   = 1'b1;
          err_d     = mid_byte;
          state_d   = DATA;
          bit_cnt_d = '0;
          first_d   = 1'b1;
        end else if (stop_c) begin
          stop_d    = 1'b1;
          err_d     = mid_byte;
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (tmo_hit) begin
          tmo_pulse_d = 1'b1;
          state_d     = IDLE;
          bit_cnt_d   = '0;
        end else if (scl_rise) begin
          if (state_q == DATA) begin
            shreg_d = {shreg_q[BYTE_W-2:0], sda_in};
            if (bit_cnt_q == LAST_BIT) begin
              state_d   = ACK;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
            end
          end else begin
            byte_d  = shreg_q;
            ack_d   = sda_in;
            addr_d  = first_q;
            valid_d = 1'b1;
            first_d = 1'b0;
            state_d = DATA;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset is synchronous and there is no RAM to clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      first_q     <= 1'b0;
      rise_pend_q <= 1'b0;
      tmo_q       <= '0;
      byte_out    <= '0;
      ack_bit     <= 1'b0;
      is_addr     <= 1'b0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      first_q     <= first_d;
      rise_pend_q <= rise_pend_d;
      tmo_q       <= tmo_d;
      byte_out    <= byte_d;
      ack_bit     <= ack_d;
      is_addr     <= addr_d;
      start_det   <= start_d;
      stop_det    <= stop_d;
      byte_valid  <= valid_d;
      frame_err   <= err_d;
      timeout     <= tmo_pulse_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_twi_frame_decoder.sv
// Self-checking bench: drives TWI bus symbols and compares the decoder's event
// stream against a symbol-level reference model.
module tb_twi_frame_decoder;

  localparam int TMO = 16;

  localparam logic [2:0] EV_ERR   = 3'd0;
  localparam logic [2:0] EV_START = 3'd1;
  localparam logic [2:0] EV_STOP  = 3'd2;
  localparam logic [2:0] EV_BYTE  = 3'd3;
  localparam logic [2:0] EV_TMO   = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
    logic       ack;
    logic       addr;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_in;
  logic       sda_in;
  logic       start_det;
  logic       stop_det;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       ack_bit;
  logic       is_addr;
  logic       frame_err;
  logic       timeout;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int q = 2;

  ev_t exp_q[$];
  ev_t obs_q[$];

  // Reference model: symbol-level view of the frame.
  bit         m_in_frame;
  bit         m_first;
  int         m_nbits;
  logic [7:0] m_acc;

  always #5 clk = ~clk;

  twi_frame_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .ack_bit    (ack_bit),
    .is_addr    (is_addr),
    .frame_err  (frame_err),
    .timeout    (timeout),
    .busy       (busy)
  );

  function automatic ev_t mk_ev(input logic [2:0] k, input logic [7:0] d,
                                input logic a, input logic f);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.ack  = a;
    e.addr = f;
    return e;
  endfunction

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err)  obs_q.push_back(mk_ev(EV_ERR,   8'h00, 1'b0, 1'b0));
    if (start_det)  obs_q.push_back(mk_ev(EV_START, 8'h00, 1'b0, 1'b0));
    if (stop_det)   obs_q.push_back(mk_ev(EV_STOP,  8'h00, 1'b0, 1'b0));
    if (byte_valid) obs_q.push_back(mk_ev(EV_BYTE,  byte_out, ack_bit, is_addr));
    if (timeout)    obs_q.push_back(mk_ev(EV_TMO,   8'h00, 1'b0, 1'b0));
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no end of run, expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic m_start();
    if (m_in_frame && m_nbits != 0) exp_q.push_back(mk_ev(EV_ERR, 8'h00, 1'b0, 1'b0));
    exp_q.push_back(mk_ev(EV_START, 8'h00, 1'b0, 1'b0));
    m_in_frame = 1;
    m_first    = 1;
    m_nbits    = 0;
    m_acc      = 8'h00;
  endtask

  task automatic m_bit(input logic b);
    if (!m_in_frame) return;
    if (m_nbits < 8) begin
      m_acc = {m_acc[6:0], b};
      m_nbits++;
    end else begin
      exp_q.push_back(mk_ev(EV_BYTE, m_acc, b, m_first));
      m_first = 0;
      m_nbits = 0;
    end
  endtask

  task automatic m_stop();
    if (!m_in_frame) return;
    if (m_nbits != 0) exp_q.push_back(mk_ev(EV_ERR, 8'h00, 1'b0, 1'b0));
    exp_q.push_back(mk_ev(EV_STOP, 8'h00, 1'b0, 1'b0));
    m_in_frame = 0;
  endtask

  // ---------------- bus drivers (SCL toggles every 2*q cycles) ----------------
  task automatic bus_start();
    if (scl_in == 1'b0) begin
      tick(q); sda_in = 1'b1;
      tick(q); scl_in = 1'b1;
      tick(q); sda_in = 1'b0;
      tick(q); scl_in = 1'b0;
    end else begin
      sda_in = 1'b0;
      tick(2 * q); scl_in = 1'b0;
    end
    m_start();
  endtask

  task automatic bus_bit(input logic b);
    tick(q); sda_in = b;
    tick(q); scl_in = 1'b1;
    tick(2 * q); scl_in = 1'b0;
    m_bit(b);
  endtask

  task automatic bus_stop();
    tick(q); sda_in = 1'b0;
    tick(q); scl_in = 1'b1;
    tick(q); sda_in = 1'b1;
    tick(q);
    m_stop();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic a);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    bus_bit(a);
  endtask

  task automatic compare_events(input string tag);
    int n;
    tick(3);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, start_det, 1'b0);
    check({tag, "_stop"},  stop_det,  1'b0);
    check({tag, "_valid"}, byte_valid, 1'b0);
    check({tag, "_byte"},  byte_out,  8'h00);
    check({tag, "_ack"},   ack_bit,   1'b0);
    check({tag, "_addr"},  is_addr,   1'b0);
    check({tag, "_err"},   frame_err, 1'b0);
    check({tag, "_tmo"},   timeout,   1'b0);
    check({tag, "_busy"},  busy,      1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    int nb;
    int mode;
    int k;

    reset = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
    m_in_frame = 0; m_first = 0; m_nbits = 0; m_acc = 8'h00;
    tick(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(2);
    check("rst_busy_after", busy, 1'b0);

    // Single address byte with ACK.
    q = 2;
    bus_start();
    check("t1_busy", busy, 1'b1);
    send_byte(8'hA0, 1'b0);
    bus_stop();
    tick(2);
    check("t1_busy_after_stop", busy, 1'b0);
    compare_events("t1");

    // Address byte then data byte with NACK.
    bus_start();
    send_byte(8'h90, 1'b0);
    send_byte(8'h5A, 1'b1);
    bus_stop();
    compare_events("t2");

    // Partial byte cut by a repeated START.
    bus_start();
    bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
    bus_start();
    send_byte(8'h91, 1'b0);
    bus_stop();
    compare_events("t3");

    // Partial byte cut by STOP.
    bus_start();
    send_byte(8'h42, 1'b0);
    for (int i = 0; i < 5; i++) bus_bit(1'(i & 1));
    bus_stop();
    tick(2);
    check("t4_busy", busy, 1'b0);
    compare_events("t4");

    // SCL stall: last SCL change is the fall that ends the 2nd bit.
    q = 1;
    bus_start();
    bus_bit(1'b1);
    bus_bit(1'b0);
    exp_q.push_back(mk_ev(EV_TMO, 8'h00, 1'b0, 1'b0));
    m_in_frame = 0;
    for (k = 1; k <= TMO + 2; k++) begin
      tick(1);
      check($sformatf("tmo_pulse_c%0d", k), timeout, (k == TMO + 1));
      check($sformatf("tmo_busy_c%0d", k), busy, (k < TMO + 1));
    end
    sda_in = 1'b1; tick(2);
    scl_in = 1'b1; tick(2);
    compare_events("tmo");

    // SCL toggling every 10 cycles never times out.
    q = 5;
    bus_start();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'($urandom));
    bus_stop();
    compare_events("slow");

    // Reset mid-frame, then a byte and a STOP without START.
    q = 2;
    bus_start();
    for (int i = 0; i < 4; i++) bus_bit(1'b1);
    compare_events("rst_pre");
    reset = 1'b1;
    m_in_frame = 0;
    tick(2);
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    send_byte(8'hFF, 1'b0);
    bus_stop();
    check("rst_post_busy", busy, 1'b0);
    compare_events("rst_post");

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      q = $urandom_range(1, 4);
      bus_start();
      check($sformatf("rnd%0d_busy", f), busy, 1'b1);
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        rb = 8'($urandom);
        send_byte(rb, 1'($urandom));
      end
      mode = $urandom_range(0, 3);
      if (mode == 1 || mode == 3) begin
        k = $urandom_range(1, 7);
        for (int i = 0; i < k; i++) bus_bit(1'($urandom));
      end
      if (mode >= 2) begin
        bus_start();
        rb = 8'($urandom);
        send_byte(rb, 1'($urandom));
      end
      bus_stop();
      tick(2);
      check($sformatf("rnd%0d_idle", f), busy, 1'b0);
      compare_events($sformatf("rnd%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
